hyper_block_mover: RTL and testbench
====================================

Name: hyper_block_mover

Overview:
- Responder end of the Gremlin block-mover command interface. Takes one issue pulse plus start/count/section/direction and moves up to 63 words in a single transfer.
- Writes: switch-side input stream -> page buffer.
- Reads: page buffer -> switch-side output stream.
- On completion it drops BLCK_WORKING and presents count/status. The controller samples these on the WORKING falling edge.

Parameters:
- DW, 32, data word width on the stream and memory ports.
- RD_LAT, 2, fixed memory read latency in cycles (1..3).
- SKID_DEPTH, 4, output skid FIFO depth; must be >= RD_LAT+1 and a power of two.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- MODE  in  2  RST_MVBLCK from controller: 01 = write-to-memory, 10 = read-from-memory, 00 = hold idle/abort, 11 = illegal
- BLCK_ISSUE  in  1  one-cycle issue pulse
- BLCK_START  in  9  first buffer address
- BLCK_COUNT_REQ  in  6  beats requested
- BLCK_SECTION  in  2  section tag
- BLCK_WORKING  out  1  transfer in progress
- BLCK_COUNT_SENT  out  6  beats completed
- BLCK_IRQ  out  1  IRQ flag carried on the last input beat
- BLCK_ABRUPT_STOP  out  1  early end, abort or illegal mode
- BLCK_FRDRAM_DEVERR  out  1  memory read error
- BLCK_ANCILL  out  25  {section[1:0], dir, count_req[5:0], stall_cnt[15:0]}
- IN_VALID / IN_READY / IN_DATA[DW] / IN_LAST / IN_IRQ  in/out/in/in/in  switch input stream
- OUT_VALID / OUT_READY / OUT_DATA[DW] / OUT_LAST  out/in/out/out  switch output stream
- MEM_ADDR  out  9  buffer address
- MEM_WE / MEM_RE  out  1  write / read strobes
- MEM_WDATA  out  DW  write data
- MEM_RDATA  in  DW  read data, valid RD_LAT cycles after MEM_RE
- MEM_ERR  in  1  error qualifier, aligned with MEM_RDATA

Behaviour:
- Reset and clocking: RST is synchronous, active-high; clock is CLK. In reset every output is 0, the FSM is IDLE and the skid FIFO is empty.
- FSM states: IDLE, WR, RD, DRAIN, DONE.
- Issue:
  - In IDLE or DONE, BLCK_ISSUE latches START, COUNT_REQ, SECTION and MODE.
  - It clears COUNT_SENT, IRQ, ABRUPT, DEVERR and stall_cnt.
  - WORKING goes to 1 on the next edge.
  - An ISSUE pulse in WR/RD/DRAIN is ignored.
- Address rule: MEM_ADDR = (start + n) mod 512 (9-bit wrap), where n is the beat index.
- Zero count: COUNT_REQ = 0 -> straight to DONE, sent = 0, no flags set.
- Illegal mode: MODE latched as 11 or 00 -> DONE with ABRUPT = 1.
- WR state:
  - IN_READY = 1.
  - Each IN_VALID & IN_READY beat: MEM_WE = 1 in the same cycle, MEM_WDATA = IN_DATA, n++.
  - Exit to DONE when n reaches req.
  - IN_LAST on a beat before n+1 == req: that beat is written, then DONE with ABRUPT = 1.
  - IRQ = IN_IRQ of the final accepted beat.
  - stall_cnt increments, saturating, on cycles with !IN_VALID.
- RD state:
  - Issue MEM_RE at start+issued while issued < req and (outstanding + FIFO occupancy) < SKID_DEPTH.
  - Returned data is pushed into the skid FIFO.
  - OUT_VALID = FIFO not empty; OUT_LAST = 1 on the beat where sent+1 == req.
  - Each OUT handshake increments sent.
  - stall_cnt increments on OUT_VALID & !OUT_READY.
  - MEM_ERR on a return: discard that word, set DEVERR, stop issuing, go to DRAIN.
  - Normal completion: sent == req and FIFO empty -> DONE.
- DRAIN: wait until outstanding reads reach 0, then flush the FIFO without emitting; OUT_VALID = 0. Then DONE.
- Abort: MODE == 00 during WR/RD -> stop immediately, ABRUPT = 1, go to DRAIN in read direction or DONE in write direction.
- DONE: WORKING = 0. All status outputs are stable from the cycle WORKING falls until the next accepted ISSUE.
- Simultaneous events:
  - IN_LAST with n+1 == req -> normal end, ABRUPT = 0.
  - MEM_ERR on the final word -> DEVERR = 1 and sent excludes that word.
- Latency:
  - ISSUE to first MEM_WE: 1 cycle plus input arrival.
  - ISSUE to first OUT_VALID: RD_LAT + 2 cycles.

Optional Feature:
- Macro: BLOCK_MOVER_WATCHDOG_EN.
- Enabled: a 12-bit no-progress counter runs in WR/RD. It reloads on any beat or memory return. At 4095 it aborts exactly like MODE == 00 and sets ABRUPT.
- Disabled: no counter; the transfer waits indefinitely.

Decomposition:
- Shared package hyperfabric_pkg:
  - MODE encodings (MODE_WR = 2'b01, MODE_RD = 2'b10).
  - FSM state enum.
  - ANCILL field offsets.
  - Address width of 9.
- Sub-module hbm_skid_fifo: synchronous FIFO, depth SKID_DEPTH, with push/pop/flush and occupancy output.

Test Plan:
- Write, start 0x1F0, count 20, IN_LAST on beat 20: addresses run 0x1F0..0x1FF then 0x000..0x003; WORKING falls; sent = 20, ABRUPT = 0.
- Write, count 10, IN_LAST with IN_IRQ on beat 4: 4 words written; sent = 4, ABRUPT = 1, IRQ = 1.
- Read, count 8, OUT_READY toggling 1/0: 8 beats in order, OUT_LAST only on beat 8, no FIFO overflow, stall_cnt = number of stall cycles.
- Read, count 16, MEM_ERR on 5th return: sent = 4, DEVERR = 1, no further OUT_VALID, WORKING falls after outstanding reads drain.
- ISSUE with count 0, then ISSUE with MODE = 11, then ISSUE during an active transfer: done with sent = 0; done with ABRUPT = 1; third pulse ignored.
- Watchdog enabled, write with IN_VALID held 0: ABRUPT = 1 and WORKING falls 4096 cycles after the first stall.

Source files
------------

// File: rtl/hyperfabric_pkg.sv
// rtl/hyperfabric_pkg.sv - shared encodings, FSM states and ANCILL layout for the block mover
package hyperfabric_pkg;

  localparam int ADDR_W = 9;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_DONE
  } hbm_state_e;

  // BLCK_ANCILL = {section[1:0], dir, count_req[5:0], stall_cnt[15:0]}
  localparam int ANC_STALL_LSB   = 0;
  localparam int ANC_COUNT_LSB   = 16;
  localparam int ANC_DIR_BIT     = 22;
  localparam int ANC_SECTION_LSB = 23;
  localparam int ANC_W           = 25;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] start,
                                                  input logic [5:0]        n);
    return start + {3'b000, n};
  endfunction

endpackage

// File: rtl/hbm_skid_fifo.sv
// rtl/hbm_skid_fifo.sv - synchronous skid FIFO with push/pop/flush and occupancy
module hbm_skid_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DW-1:0]          head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] slot_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) slot_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head_data = slot_q[rd_ptr_q[AW-1:0]];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign occupancy = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/hyper_block_mover.sv
// rtl/hyper_block_mover.sv - Gremlin block-mover responder between page buffer and switch streams
// Optional no-progress watchdog: define BLOCK_MOVER_WATCHDOG_EN.
module hyper_block_mover
  import hyperfabric_pkg::*;
#(
  parameter int DW         = 32,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        MODE,
  input  logic              BLCK_ISSUE,
  input  logic [ADDR_W-1:0] BLCK_START,
  input  logic [5:0]        BLCK_COUNT_REQ,
  input  logic [1:0]        BLCK_SECTION,
  output logic              BLCK_WORKING,
  output logic [5:0]        BLCK_COUNT_SENT,
  output logic              BLCK_IRQ,
  output logic              BLCK_ABRUPT_STOP,
  output logic              BLCK_FRDRAM_DEVERR,
  output logic [ANC_W-1:0]  BLCK_ANCILL,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DW-1:0]     IN_DATA,
  input  logic              IN_LAST,
  input  logic              IN_IRQ,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DW-1:0]     OUT_DATA,
  output logic              OUT_LAST,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic              MEM_RE,
  output logic [DW-1:0]     MEM_WDATA,
  input  logic [DW-1:0]     MEM_RDATA,
  input  logic              MEM_ERR
);

  localparam int OCC_W = $clog2(SKID_DEPTH) + 1;

  hbm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [5:0]        req_q, req_d;
  logic [5:0]        sent_q, sent_d;
  logic [5:0]        issued_q, issued_d;
  logic [1:0]        section_q, section_d;
  logic              dir_q, dir_d;
  logic              irq_q, irq_d;
  logic              abrupt_q, abrupt_d;
  logic              deverr_q, deverr_d;
  logic [15:0]       stall_q, stall_d;
  logic [RD_LAT-1:0] rv_q, rv_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [DW-1:0]     fifo_head;
  logic [OCC_W-1:0]  fifo_occ;
  logic [7:0]        outstanding;
  logic              ret_valid, err_now, abort_now, wd_expired;
  logic              in_fire, out_fire, active;

  hbm_skid_fifo #(.DW(DW), .DEPTH(SKID_DEPTH)) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fifo_push),
    .push_data (MEM_RDATA),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign active = (state_q == ST_WR) || (state_q == ST_RD);

`ifdef BLOCK_MOVER_WATCHDOG_EN
  logic [11:0] wd_q, wd_d;
  logic        progress;

  assign progress = in_fire || out_fire || ret_valid;

  always_comb begin
    wd_d = '0;
    if (active) wd_d = progress ? 12'd0 : wd_q + 12'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  assign wd_expired = active && (wd_q == 12'hFFF);
`else
  assign wd_expired = 1'b0;
`endif

  // rv_q tracks reads in flight; the oldest stage lines up with MEM_RDATA.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LAT; i++) outstanding = outstanding + {7'd0, rv_q[i]};
  end

  assign ret_valid = rv_q[RD_LAT-1];
  assign abort_now = active && ((MODE == MODE_IDLE) || wd_expired);
  assign err_now   = (state_q == ST_RD) && ret_valid && MEM_ERR;

  always_comb begin
    IN_READY  = (state_q == ST_WR) && !abort_now;
    in_fire   = IN_READY && IN_VALID;
    OUT_VALID = (state_q == ST_RD) && !fifo_empty && !abort_now;
    out_fire  = OUT_VALID && OUT_READY;
    OUT_LAST  = OUT_VALID && (sent_q + 6'd1 == req_q);
    OUT_DATA  = OUT_VALID ? fifo_head : '0;
    MEM_WE    = in_fire;
    MEM_WDATA = in_fire ? IN_DATA : '0;
    MEM_RE    = (state_q == ST_RD) && !abort_now && !err_now && (issued_q < req_q)
                && ((outstanding + 8'(fifo_occ)) < 8'(SKID_DEPTH));
    MEM_ADDR  = '0;
    if (MEM_WE)      MEM_ADDR = beat_addr(start_q, sent_q);
    else if (MEM_RE) MEM_ADDR = beat_addr(start_q, issued_q);
    fifo_pop  = out_fire;
    rv_d[0]   = MEM_RE;
    for (int i = 1; i < RD_LAT; i++) rv_d[i] = rv_q[i-1];
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    req_d      = req_q;
    sent_d     = sent_q;
    issued_d   = issued_q;
    section_d  = section_q;
    dir_d      = dir_q;
    irq_d      = irq_q;
    abrupt_d   = abrupt_q;
    deverr_d   = deverr_q;
    stall_d    = stall_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (BLCK_ISSUE) begin
          start_d   = BLCK_START;
          req_d     = BLCK_COUNT_REQ;
          section_d = BLCK_SECTION;
          dir_d     = (MODE == MODE_RD);
          sent_d    = '0;
          issued_d  = '0;
          irq_d     = 1'b0;
          abrupt_d  = 1'b0;
          deverr_d  = 1'b0;
          stall_d   = '0;
          if (MODE != MODE_WR && MODE != MODE_RD) begin
            abrupt_d = 1'b1;
            state_d  = ST_DONE;
          end else if (BLCK_COUNT_REQ == 6'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = (MODE == MODE_WR) ? ST_WR : ST_RD;
          end
        end
      end
      ST_WR: begin
        if (!IN_VALID && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        if (abort_now) begin
          abrupt_d = 1'b1;
          state_d  = ST_DONE;
        end else if (in_fire) begin
          sent_d = sent_q + 6'd1;
          irq_d  = IN_IRQ;
          if (sent_q + 6'd1 == req_q) begin
            state_d = ST_DONE;
          end else if (IN_LAST) begin
            abrupt_d = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_RD: begin
        if (OUT_VALID && !OUT_READY && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        if (MEM_RE)   issued_d = issued_q + 6'd1;
        if (out_fire) sent_d   = sent_q + 6'd1;
        if (abort_now) begin
          abrupt_d = 1'b1;
          state_d  = ST_DRAIN;
        end else if (err_now) begin
          deverr_d = 1'b1;
          state_d  = ST_DRAIN;
        end else begin
          fifo_push = ret_valid;
          if (sent_q == req_q && fifo_empty) state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        // Late returns are dropped; the FIFO is discarded once nothing is in flight.
        if (outstanding == 8'd0) begin
          fifo_flush = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      start_q   <= '0;
      req_q     <= '0;
      sent_q    <= '0;
      issued_q  <= '0;
      section_q <= '0;
      dir_q     <= 1'b0;
      irq_q     <= 1'b0;
      abrupt_q  <= 1'b0;
      deverr_q  <= 1'b0;
      stall_q   <= '0;
      rv_q      <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      req_q     <= req_d;
      sent_q    <= sent_d;
      issued_q  <= issued_d;
      section_q <= section_d;
      dir_q     <= dir_d;
      irq_q     <= irq_d;
      abrupt_q  <= abrupt_d;
      deverr_q  <= deverr_d;
      stall_q   <= stall_d;
      rv_q      <= rv_d;
    end
  end

  always_comb begin
    BLCK_ANCILL = '0;
    BLCK_ANCILL[ANC_STALL_LSB +: 16]  = stall_q;
    BLCK_ANCILL[ANC_COUNT_LSB +: 6]   = req_q;
    BLCK_ANCILL[ANC_DIR_BIT]          = dir_q;
    BLCK_ANCILL[ANC_SECTION_LSB +: 2] = section_q;
  end

  assign BLCK_WORKING       = active || (state_q == ST_DRAIN);
  assign BLCK_COUNT_SENT    = sent_q;
  assign BLCK_IRQ           = irq_q;
  assign BLCK_ABRUPT_STOP   = abrupt_q;
  assign BLCK_FRDRAM_DEVERR = deverr_q;

endmodule

// File: tb/tb_hyper_block_mover.sv
// tb/tb_hyper_block_mover.sv - directed self-checking bench for hyper_block_mover
module tb_hyper_block_mover;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic [1:0]    MODE;
  logic          BLCK_ISSUE;
  logic [8:0]    BLCK_START;
  logic [5:0]    BLCK_COUNT_REQ;
  logic [1:0]    BLCK_SECTION;
  logic          BLCK_WORKING;
  logic [5:0]    BLCK_COUNT_SENT;
  logic          BLCK_IRQ;
  logic          BLCK_ABRUPT_STOP;
  logic          BLCK_FRDRAM_DEVERR;
  logic [24:0]   BLCK_ANCILL;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic          IN_LAST;
  logic          IN_IRQ;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_LAST;
  logic [8:0]    MEM_ADDR;
  logic          MEM_WE;
  logic          MEM_RE;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  hyper_block_mover #(.DW(DW), .RD_LAT(2), .SKID_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .BLCK_ISSUE(BLCK_ISSUE),
    .BLCK_START(BLCK_START), .BLCK_COUNT_REQ(BLCK_COUNT_REQ), .BLCK_SECTION(BLCK_SECTION),
    .BLCK_WORKING(BLCK_WORKING), .BLCK_COUNT_SENT(BLCK_COUNT_SENT), .BLCK_IRQ(BLCK_IRQ),
    .BLCK_ABRUPT_STOP(BLCK_ABRUPT_STOP), .BLCK_FRDRAM_DEVERR(BLCK_FRDRAM_DEVERR),
    .BLCK_ANCILL(BLCK_ANCILL), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .IN_LAST(IN_LAST), .IN_IRQ(IN_IRQ), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
    .MEM_RE(MEM_RE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ERR(MEM_ERR)
  );

  // Page buffer model: read data is a fixed pattern of the address, RD_LAT = 2.
  logic [1:0]  pv = 2'b00;
  logic [8:0]  pa0 = '0, pa1 = '0;
  int          ret_idx = 0;
  int          err_at = 0;
  int          mon_stall = 0;
  int          re_cnt = 0;
  logic [8:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] out_data_q[$];
  logic        out_last_q[$];

  assign MEM_RDATA = pv[1] ? (32'hD000_0000 | {23'd0, pa1}) : '0;
  assign MEM_ERR   = pv[1] && (ret_idx + 1 == err_at);

  always @(posedge CLK) begin
    pv  <= {pv[0], MEM_RE};
    pa0 <= MEM_ADDR;
    pa1 <= pa0;
    if (MEM_RE) re_cnt <= re_cnt + 1;
    if (BLCK_ISSUE) begin
      mon_stall <= 0;
      ret_idx   <= 0;
    end else begin
      if (OUT_VALID && !OUT_READY) mon_stall <= mon_stall + 1;
      if (pv[1]) ret_idx <= ret_idx + 1;
    end
    if (MEM_WE) begin
      wr_addr_q.push_back(MEM_ADDR);
      wr_data_q.push_back(MEM_WDATA);
    end
    if (OUT_VALID && OUT_READY) begin
      out_data_q.push_back(OUT_DATA);
      out_last_q.push_back(OUT_LAST);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] mode, input logic [8:0] start,
                       input logic [5:0] cnt, input logic [1:0] sec);
    MODE = mode; BLCK_START = start; BLCK_COUNT_REQ = cnt; BLCK_SECTION = sec;
    BLCK_ISSUE = 1'b1;
    @(negedge CLK);
    BLCK_ISSUE = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (BLCK_WORKING && cycles < budget) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  task automatic send_beats(input int nbeats, input int last_at, input int irq_at);
    int i = 0;
    int guard = 0;
    while (i < nbeats && guard < 200) begin
      IN_VALID = 1'b1;
      IN_DATA  = 32'hA000_0000 + i;
      IN_LAST  = (i + 1 == last_at);
      IN_IRQ   = (i + 1 == irq_at);
      #1;
      if (IN_READY) i++;
      @(negedge CLK);
      guard++;
    end
    IN_VALID = 1'b0; IN_LAST = 1'b0; IN_IRQ = 1'b0; IN_DATA = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    int base;
    int first;
    logic bad;

    RST = 1'b1; MODE = 2'b00; BLCK_ISSUE = 1'b0; BLCK_START = '0; BLCK_COUNT_REQ = '0;
    BLCK_SECTION = '0; IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0; IN_IRQ = 1'b0;
    OUT_READY = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_working", BLCK_WORKING, 0);
    check("rst_sent", BLCK_COUNT_SENT, 0);
    check("rst_flags", {BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 0);
    check("rst_ancill", BLCK_ANCILL, 0);
    check("rst_strobes", {MEM_WE, MEM_RE, OUT_VALID, IN_READY, MEM_ADDR}, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Write 20 beats from 0x1F0, wrapping past 0x1FF.
    base = wr_addr_q.size();
    issue(2'b01, 9'h1F0, 6'd20, 2'b10);
    check("t1_working", BLCK_WORKING, 1);
    check("t1_first_ready", IN_READY, 1);
    send_beats(20, 20, 0);
    wait_idle(50, cyc);
    check("t1_done", BLCK_WORKING, 0);
    check("t1_nwrites", wr_addr_q.size() - base, 20);
    for (int k = 0; k < 20; k++) begin
      if (base + k < wr_addr_q.size()) begin
        check($sformatf("t1_addr%0d", k), wr_addr_q[base+k], (9'h1F0 + k) & 9'h1FF);
        check($sformatf("t1_data%0d", k), wr_data_q[base+k], 32'hA000_0000 + k);
      end
    end
    check("t1_sent", BLCK_COUNT_SENT, 20);
    check("t1_abrupt", BLCK_ABRUPT_STOP, 0);
    check("t1_ancill", BLCK_ANCILL, {2'b10, 1'b0, 6'd20, 16'd0});

    // Write 10 requested, IN_LAST with IRQ on beat 4.
    base = wr_addr_q.size();
    issue(2'b01, 9'h010, 6'd10, 2'b01);
    send_beats(4, 4, 4);
    wait_idle(50, cyc);
    check("t2_done", BLCK_WORKING, 0);
    check("t2_nwrites", wr_addr_q.size() - base, 4);
    check("t2_sent", BLCK_COUNT_SENT, 4);
    check("t2_abrupt", BLCK_ABRUPT_STOP, 1);
    check("t2_irq", BLCK_IRQ, 1);
    @(negedge CLK);
    check("t2_status_stable", {BLCK_COUNT_SENT, BLCK_ABRUPT_STOP, BLCK_IRQ}, {6'd4, 1'b1, 1'b1});

    // Read 8 from 0x1FC with OUT_READY toggling.
    base = out_data_q.size();
    first = 0;
    cyc = re_cnt;
    issue(2'b10, 9'h1FC, 6'd8, 2'b01);
    for (int c = 1; c < 200 && BLCK_WORKING; c++) begin
      if (OUT_VALID && first == 0) first = c;
      OUT_READY = c[0];
      @(negedge CLK);
    end
    OUT_READY = 1'b0;
    check("t3_done", BLCK_WORKING, 0);
    check("t3_first_valid", first, 4);
    check("t3_nreads", re_cnt - cyc, 8);
    check("t3_nbeats", out_data_q.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < out_data_q.size()) begin
        check($sformatf("t3_data%0d", k), out_data_q[base+k],
              32'hD000_0000 | ((9'h1FC + k) & 9'h1FF));
        check($sformatf("t3_last%0d", k), out_last_q[base+k], (k == 7));
      end
    end
    check("t3_sent", BLCK_COUNT_SENT, 8);
    check("t3_flags", {BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 0);
    check("t3_stall_nonzero", mon_stall > 0, 1);
    check("t3_ancill", BLCK_ANCILL, {2'b01, 1'b1, 6'd8, 16'(mon_stall)});

    // Read 16 with MEM_ERR on the fifth return.
    base = out_data_q.size();
    err_at = 5;
    OUT_READY = 1'b1;
    bad = 1'b0;
    issue(2'b10, 9'h040, 6'd16, 2'b00);
    for (int c = 0; c < 200 && BLCK_WORKING; c++) begin
      if (BLCK_FRDRAM_DEVERR && OUT_VALID) bad = 1'b1;
      @(negedge CLK);
    end
    err_at = 0;
    check("t4_done", BLCK_WORKING, 0);
    check("t4_no_valid_after_err", bad, 0);
    check("t4_drained", pv, 0);
    check("t4_nbeats", out_data_q.size() - base, 4);
    if (base + 3 < out_data_q.size())
      check("t4_data3", out_data_q[base+3], 32'hD000_0043);
    check("t4_sent", BLCK_COUNT_SENT, 4);
    check("t4_deverr", BLCK_FRDRAM_DEVERR, 1);

    // Zero count, illegal mode, then an ignored ISSUE mid-transfer.
    issue(2'b01, 9'h000, 6'd0, 2'b00);
    @(negedge CLK);
    check("t5_zero_working", BLCK_WORKING, 0);
    check("t5_zero_status", {BLCK_COUNT_SENT, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR, BLCK_IRQ}, 0);
    issue(2'b11, 9'h000, 6'd5, 2'b00);
    @(negedge CLK);
    check("t5_illegal_working", BLCK_WORKING, 0);
    check("t5_illegal_abrupt", BLCK_ABRUPT_STOP, 1);
    check("t5_illegal_sent", BLCK_COUNT_SENT, 0);
    OUT_READY = 1'b0;
    issue(2'b10, 9'h080, 6'd3, 2'b00);
    repeat (6) @(negedge CLK);
    issue(2'b01, 9'h100, 6'd7, 2'b11);
    check("t5_ignored_working", BLCK_WORKING, 1);
    check("t5_ignored_ancill", BLCK_ANCILL[24:16], {2'b00, 1'b1, 6'd3});
    OUT_READY = 1'b1;
    wait_idle(50, cyc);
    OUT_READY = 1'b0;
    check("t5_done", BLCK_WORKING, 0);
    check("t5_sent", BLCK_COUNT_SENT, 3);
    check("t5_abrupt", BLCK_ABRUPT_STOP, 0);

`ifdef BLOCK_MOVER_WATCHDOG_EN
    issue(2'b01, 9'h020, 6'd5, 2'b00);
    wait_idle(5000, cyc);
    check("t6_wd_cycles", cyc, 4096);
    check("t6_wd_abrupt", BLCK_ABRUPT_STOP, 1);
    check("t6_wd_sent", BLCK_COUNT_SENT, 0);
`else
    issue(2'b01, 9'h020, 6'd5, 2'b00);
    repeat (10) @(negedge CLK);
    check("t6_waiting", BLCK_WORKING, 1);
    MODE = 2'b00;
    @(negedge CLK);
    check("t6_abort_working", BLCK_WORKING, 0);
    check("t6_abort_abrupt", BLCK_ABRUPT_STOP, 1);
    check("t6_abort_sent", BLCK_COUNT_SENT, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
